// File: rtl/bru_pkg.sv
// bru_pkg: shared types, counter constants and condition helper for branch_resolve_unit
package bru_pkg;

    typedef enum logic [1:0] {
        BJ_NONE   = 2'b00,
        BJ_JUMP   = 2'b01,
        BJ_BRANCH = 2'b10
    } bj_e;

    typedef enum logic [2:0] {
        BR_NZ = 3'b000,
        BR_EZ = 3'b001,
        BR_LT = 3'b010,
        BR_GT = 3'b011,
        BR_LE = 3'b100,
        BR_GE = 3'b101
    } br_type_e;

    localparam logic [1:0] CNT_RESET = 2'b01;
    localparam logic [1:0] CNT_MAX   = 2'b11;
    localparam logic [1:0] CNT_MIN   = 2'b00;

    // Encodings 11x have no enum member and resolve as never taken.
    function automatic logic cond_true(input logic [2:0] t, input logic z, input logic s, input logic o);
        logic lt;
        lt = s ^ o;
        return t == BR_NZ ? !z :
               t == BR_EZ ? z :
               t == BR_LT ? lt :
               t == BR_GT ? (!lt & !z) :
               t == BR_LE ? (lt | z) :
               t == BR_GE ? !lt : 1'b0;
    endfunction

endpackage

// File: rtl/bru_pred_table.sv
// bru_pred_table: 2-bit saturating counter table with one write port and a combinational read port
module bru_pred_table
    import bru_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic             i_wr_taken,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic             o_rd_taken
);

    logic [1:0] r_cnt [ENTRIES];
    logic [1:0] w_cur;

    assign w_cur      = r_cnt[i_wr_idx];
    assign o_rd_taken = r_cnt[i_rd_idx][1];

    // Saturating train of the addressed counter; lookup sees the new value only after the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) r_cnt[i] <= CNT_RESET;
        end else if (i_wr_en) begin
            r_cnt[i_wr_idx] <= i_wr_taken ? (w_cur == CNT_MAX ? w_cur : w_cur + 2'b01)
                                          : (w_cur == CNT_MIN ? w_cur : w_cur - 2'b01);
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: registered branch/jump resolution with mispredict flag; predictor table under BRU_PREDICTOR_EN
module branch_resolve_unit
    import bru_pkg::*;
#(
    parameter int PC_W         = 36,
    parameter int IMM_W        = 25,
    parameter int PRED_ENTRIES = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PC_W-1:0]  in_pc,
    input  logic [1:0]       in_branch_jump,
    input  logic [2:0]       in_branch_type,
    input  logic             in_branch_register,
    input  logic [IMM_W-1:0] in_immediate,
    input  logic [PC_W-1:0]  in_register,
    input  logic             in_zero,
    input  logic             in_sign,
    input  logic             in_overflow,
    input  logic [PC_W-1:0]  in_pred_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PC_W-1:0]  out_pc_next,
    output logic             out_taken,
    output logic             out_mispredict,
    input  logic [PC_W-1:0]  lookup_pc,
    output logic             lookup_taken
);

    localparam int IDX_W = $clog2(PRED_ENTRIES);

    logic             r_out_valid;
    logic [PC_W-1:0]  r_pc_next;
    logic             r_taken;
    logic             r_mispredict;
    logic             r_is_branch;
    logic [IDX_W-1:0] r_idx;

    logic             w_accept;
    logic             w_is_branch;
    logic             w_taken;
    logic [PC_W-1:0]  w_imm_ext;
    logic [PC_W-1:0]  w_target;
    logic [PC_W-1:0]  w_pc_next;
    logic             w_unused;

    assign in_ready    = !flush & (!r_out_valid | out_ready);
    assign w_accept    = in_valid & in_ready;
    assign w_is_branch = in_branch_jump == BJ_BRANCH;
    assign w_imm_ext   = {{(PC_W-IMM_W){in_immediate[IMM_W-1]}}, in_immediate};
    assign w_target    = in_pc + w_imm_ext + (in_branch_register ? in_register : '0);
    assign w_taken     = (in_branch_jump == BJ_JUMP) | (w_is_branch & cond_true(in_branch_type, in_zero, in_sign, in_overflow));
    assign w_pc_next   = w_taken ? w_target : in_pc;

    assign out_valid      = r_out_valid;
    assign out_pc_next    = r_pc_next;
    assign out_taken      = r_taken;
    assign out_mispredict = r_mispredict;

    // Output register: flush wins, then a new accept replaces the result, else a handshake empties it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_pc_next    <= '0;
            r_taken      <= 1'b0;
            r_mispredict <= 1'b0;
            r_is_branch  <= 1'b0;
            r_idx        <= '0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out_valid  <= 1'b1;
            r_pc_next    <= w_pc_next;
            r_taken      <= w_taken;
            r_mispredict <= w_pc_next != in_pred_pc;
            r_is_branch  <= w_is_branch;
            r_idx        <= in_pc[IDX_W-1:0];
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

`ifdef BRU_PREDICTOR_EN
    logic w_upd_en;

    assign w_upd_en = r_out_valid & out_ready & !flush & r_is_branch;
    assign w_unused = ^lookup_pc[PC_W-1:IDX_W];

    bru_pred_table #(.ENTRIES(PRED_ENTRIES)) u_pred (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_wr_en    (w_upd_en),
        .i_wr_idx   (r_idx),
        .i_wr_taken (r_taken),
        .i_rd_idx   (lookup_pc[IDX_W-1:0]),
        .o_rd_taken (lookup_taken)
    );
`else
    assign lookup_taken = 1'b0;
    assign w_unused     = ^{lookup_pc, r_is_branch, r_idx};
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed vector table plus hand-written handshake, flush, reset and predictor sequences
module tb_branch_resolve_unit;

`ifdef BRU_PREDICTOR_EN
    localparam bit PRED = 1'b1;
`else
    localparam bit PRED = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [35:0] in_pc;
    logic [1:0]  in_branch_jump;
    logic [2:0]  in_branch_type;
    logic        in_branch_register;
    logic [24:0] in_immediate;
    logic [35:0] in_register;
    logic        in_zero, in_sign, in_overflow;
    logic [35:0] in_pred_pc;
    logic        out_valid;
    logic        out_ready;
    logic [35:0] out_pc_next;
    logic        out_taken;
    logic        out_mispredict;
    logic [35:0] lookup_pc;
    logic        lookup_taken;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [35:0] pc;
        logic [1:0]  bj;
        logic [2:0]  bt;
        logic        br;
        logic [24:0] imm;
        logic [35:0] rg;
        logic        z, s, o;
        logic [35:0] pred;
        logic [35:0] exp_pc;
        logic        exp_t;
        logic        exp_m;
    } vec_t;

    vec_t vecs[14];

    branch_resolve_unit dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .flush              (flush),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .in_pc              (in_pc),
        .in_branch_jump     (in_branch_jump),
        .in_branch_type     (in_branch_type),
        .in_branch_register (in_branch_register),
        .in_immediate       (in_immediate),
        .in_register        (in_register),
        .in_zero            (in_zero),
        .in_sign            (in_sign),
        .in_overflow        (in_overflow),
        .in_pred_pc         (in_pred_pc),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .out_pc_next        (out_pc_next),
        .out_taken          (out_taken),
        .out_mispredict     (out_mispredict),
        .lookup_pc          (lookup_pc),
        .lookup_taken       (lookup_taken)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [35:0] act, input logic [35:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        in_valid           = 1'b1;
        in_pc              = v.pc;
        in_branch_jump     = v.bj;
        in_branch_type     = v.bt;
        in_branch_register = v.br;
        in_immediate       = v.imm;
        in_register        = v.rg;
        in_zero            = v.z;
        in_sign            = v.s;
        in_overflow        = v.o;
        in_pred_pc         = v.pred;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic jump(input logic [35:0] pc, input logic [24:0] imm);
        apply('{pc, 2'b01, 3'b000, 1'b0, imm, 36'h0, 1'b0, 1'b0, 1'b0, 36'h0, 36'h0, 1'b0, 1'b0});
    endtask

    // one instruction at predictor index of pc, checking lookup before and after its handshake edge
    task automatic pred_step(input string nm, input logic [1:0] bj, input logic z, input logic exp_before, input logic exp_after);
        apply('{36'h13, bj, 3'b000, 1'b0, 25'h4, 36'h0, z, 1'b0, 1'b0, 36'h17, 36'h0, 1'b0, 1'b0});
        step();
        in_valid = 1'b0;
        chk({nm, "_old"}, lookup_taken, exp_before & PRED);
        step();
        chk({nm, "_new"}, lookup_taken, exp_after & PRED);
    endtask

    initial begin
        vecs[0]  = '{36'h100, 2'b01, 3'b000, 1'b1, 25'h10,      36'h20, 1'b0, 1'b0, 1'b0, 36'h130, 36'h130, 1'b1, 1'b0};
        vecs[1]  = '{36'h40,  2'b10, 3'b010, 1'b0, 25'h1FFFFFC, 36'h0,  1'b0, 1'b1, 1'b0, 36'h40,  36'h3C,  1'b1, 1'b1};
        vecs[2]  = '{36'h50,  2'b10, 3'b011, 1'b0, 25'h8,       36'h0,  1'b1, 1'b0, 1'b0, 36'h58,  36'h50,  1'b0, 1'b1};
        vecs[3]  = '{36'h60,  2'b10, 3'b010, 1'b0, 25'h8,       36'h0,  1'b0, 1'b1, 1'b1, 36'h60,  36'h60,  1'b0, 1'b0};
        vecs[4]  = '{36'h70,  2'b10, 3'b110, 1'b0, 25'h8,       36'h0,  1'b1, 1'b0, 1'b0, 36'h70,  36'h70,  1'b0, 1'b0};
        vecs[5]  = '{36'h80,  2'b10, 3'b000, 1'b0, 25'h20,      36'h0,  1'b0, 1'b0, 1'b0, 36'h80,  36'hA0,  1'b1, 1'b1};
        vecs[6]  = '{36'h90,  2'b10, 3'b001, 1'b0, 25'h4,       36'h0,  1'b1, 1'b0, 1'b0, 36'h94,  36'h94,  1'b1, 1'b0};
        vecs[7]  = '{36'hA0,  2'b10, 3'b100, 1'b0, 25'h100,     36'h0,  1'b1, 1'b0, 1'b0, 36'h1A0, 36'h1A0, 1'b1, 1'b0};
        vecs[8]  = '{36'hB0,  2'b10, 3'b101, 1'b0, 25'h10,      36'h0,  1'b0, 1'b1, 1'b1, 36'hB0,  36'hC0,  1'b1, 1'b1};
        vecs[9]  = '{36'hC0,  2'b00, 3'b000, 1'b0, 25'h10,      36'h0,  1'b0, 1'b0, 1'b0, 36'hC0,  36'hC0,  1'b0, 1'b0};
        vecs[10] = '{36'hD0,  2'b11, 3'b000, 1'b0, 25'h10,      36'h0,  1'b0, 1'b0, 1'b0, 36'h0,   36'hD0,  1'b0, 1'b1};
        vecs[11] = '{36'hFFFFFFFF0, 2'b01, 3'b000, 1'b0, 25'h20, 36'h0, 1'b0, 1'b0, 1'b0, 36'h10,  36'h10,  1'b1, 1'b0};
        vecs[12] = '{36'h1000, 2'b01, 3'b000, 1'b1, 25'h1FFFF00, 36'h10, 1'b0, 1'b0, 1'b0, 36'h0,  36'hF10,  1'b1, 1'b1};
        vecs[13] = '{36'hE0,  2'b10, 3'b101, 1'b0, 25'h4,       36'h0,  1'b0, 1'b1, 1'b0, 36'hE4,  36'hE0,  1'b0, 1'b1};

        rst_n = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        lookup_pc = 36'h0;
        apply(vecs[0]);
        in_valid = 1'b0;
        repeat (2) step();
        chk("rst_valid", out_valid, 0);
        chk("rst_pc", out_pc_next, 0);
        chk("rst_taken", out_taken, 0);
        chk("rst_mis", out_mispredict, 0);
        chk("rst_lookup", lookup_taken, 0);
        chk("rst_in_ready", in_ready, 1);
        @(negedge clk) rst_n = 1'b1;

        // back-to-back resolution table
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            apply(vecs[i]);
            step();
            chk($sformatf("v%0d_valid", i), out_valid, 1);
            chk($sformatf("v%0d_pc", i), out_pc_next, vecs[i].exp_pc);
            chk($sformatf("v%0d_taken", i), out_taken, vecs[i].exp_t);
            chk($sformatf("v%0d_mis", i), out_mispredict, vecs[i].exp_m);
        end
        in_valid = 1'b0;
        step();
        chk("drain_valid", out_valid, 0);
        chk("idx0_trained", lookup_taken, PRED);

        // async reset while a result is held
        jump(36'h100, 25'h30);
        step();
        chk("pre_rst_valid", out_valid, 1);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_pc", out_pc_next, 0);
        chk("mid_rst_taken", out_taken, 0);
        chk("mid_rst_lookup", lookup_taken, 0);
        @(negedge clk) rst_n = 1'b1;

        // flush beats a simultaneous output handshake and blocks accept
        apply('{36'h20, 2'b10, 3'b000, 1'b0, 25'h4, 36'h0, 1'b0, 1'b0, 1'b0, 36'h24, 36'h0, 1'b0, 1'b0});
        step();
        chk("fl_valid_before", out_valid, 1);
        jump(36'h500, 25'h4);
        flush = 1'b1;
        #1;
        chk("fl_in_ready", in_ready, 0);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl_valid_after", out_valid, 0);
        chk("fl_no_update", lookup_taken, 0);
        step();
        chk("fl_no_accept", out_valid, 0);

        // back-pressure hold then release with no bubble
        out_ready = 1'b0;
        jump(36'h200, 25'h10);
        step();
        jump(36'h300, 25'h20);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("bp%0d_in_ready", i), in_ready, 0);
            step();
            chk($sformatf("bp%0d_valid", i), out_valid, 1);
            chk($sformatf("bp%0d_pc", i), out_pc_next, 36'h210);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", in_ready, 1);
        step();
        chk("bp_b_valid", out_valid, 1);
        chk("bp_b_pc", out_pc_next, 36'h320);
        jump(36'h400, 25'h8);
        step();
        chk("bp_c_valid", out_valid, 1);
        chk("bp_c_pc", out_pc_next, 36'h408);
        in_valid = 1'b0;
        step();
        chk("bp_drain", out_valid, 0);

        // predictor training at index 3 through a lookup pc with different upper bits
        lookup_pc = 36'h53;
        pred_step("t1", 2'b10, 1'b0, 1'b0, 1'b1);
        pred_step("t2", 2'b10, 1'b0, 1'b1, 1'b1);
        pred_step("t3", 2'b10, 1'b0, 1'b1, 1'b1);
        pred_step("n1", 2'b10, 1'b1, 1'b1, 1'b1);
        pred_step("none", 2'b00, 1'b1, 1'b1, 1'b1);
        pred_step("n2", 2'b10, 1'b1, 1'b1, 1'b0);
        pred_step("n3", 2'b10, 1'b1, 1'b0, 1'b0);
        pred_step("n4", 2'b10, 1'b1, 1'b0, 1'b0);
        pred_step("t5", 2'b10, 1'b0, 1'b0, 1'b0);
        pred_step("t6", 2'b10, 1'b0, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
